// File: rtl/nn_cls_pkg.sv
// Shared types and constants for the classifier-layer scheduler: FSM states,
// default geometry and the Q6.10 fixed-point data format.
package nn_cls_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_BIAS,
    S_DRAIN,
    S_ACT,
    S_WRITE,
    S_DONE
  } state_t;

  localparam int N_FEAT_DEF = 9;
  localparam int N_LANE_DEF = 3;

  localparam int DATA_W   = 16;
  localparam int Q_INT_W  = 6;
  localparam int Q_FRAC_W = 10;
  localparam logic [DATA_W-1:0] Q_ONE = 16'h0400;

endpackage

// File: rtl/nn_cls_valid_dly.sv
// Delay line that re-aligns the {mac, bias} read strobes with BRAM output data.
// Freezes when i_en is low so a stalled schedule resumes at the same step.
module nn_cls_valid_dly #(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic       i_clr,
  input  logic [1:0] i_d,
  output logic [1:0] o_q
);

  logic [1:0] r_sr [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
    end else if (i_en) begin
      r_sr[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/nn_cls_scheduler.sv
// Sequences one classifier inference: feature/weight reads, bias fetch, pipeline
// drain, activation, result write-back of N_LANE lanes plus an unhealthy flag.
module nn_cls_scheduler
  import nn_cls_pkg::*;
#(
  parameter int N_FEAT   = N_FEAT_DEF,
  parameter int N_LANE   = N_LANE_DEF,
  parameter int ADDR_W   = 4,
  parameter int BRAM_LAT = 1,
  parameter int ACT_LAT  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic              start,
  output logic              ready,
  output logic              done,
  output logic              xij_enb,
  output logic [ADDR_W-1:0] xij_addrb,
  output logic              wb_enb,
  output logic [ADDR_W-1:0] wb_addrb,
  output logic              acc_clr,
  output logic              mac_valid,
  output logic              bias_valid,
  output logic              act_en,
  output logic              xout_ena,
  output logic [7:0]        xout_wea,
  output logic [ADDR_W-1:0] xout_addra,
  output logic [1:0]        xout_sel
);

  localparam logic [7:0]        C_READ_LAST  = 8'(N_FEAT - 1);
  localparam logic [7:0]        C_DRAIN_LAST = 8'(BRAM_LAT - 1);
  localparam logic [7:0]        C_ACT_LAST   = 8'(ACT_LAT - 1);
  localparam logic [7:0]        C_WR_LAST    = 8'(N_LANE);
  localparam logic [ADDR_W-1:0] C_BIAS_ADDR  = ADDR_W'(N_FEAT);

  state_t     r_state, w_state_next;
  logic [7:0] r_cnt, w_cnt_next;
  logic [1:0] w_dly_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // A single step counter serves every multi-cycle state; it restarts at 0 on each entry.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    done         = 1'b0;
    xij_enb      = 1'b0;
    xij_addrb    = '0;
    wb_enb       = 1'b0;
    wb_addrb     = '0;
    acc_clr      = 1'b0;
    act_en       = 1'b0;
    xout_ena     = 1'b0;
    xout_wea     = '0;
    xout_addra   = '0;
    xout_sel     = '0;
    if (en) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state_next = S_READ;
            w_cnt_next   = '0;
          end
        end
        S_READ: begin
          xij_enb   = 1'b1;
          wb_enb    = 1'b1;
          xij_addrb = r_cnt[ADDR_W-1:0];
          wb_addrb  = r_cnt[ADDR_W-1:0];
          acc_clr   = (r_cnt == '0);
          if (r_cnt == C_READ_LAST) begin
            w_state_next = S_BIAS;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 8'd1;
          end
        end
        S_BIAS: begin
          wb_enb       = 1'b1;
          wb_addrb     = C_BIAS_ADDR;
          w_state_next = S_DRAIN;
          w_cnt_next   = '0;
        end
        S_DRAIN: begin
          if (r_cnt == C_DRAIN_LAST) begin
            w_state_next = S_ACT;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 8'd1;
          end
        end
        S_ACT: begin
          act_en = (r_cnt == '0);
          if (r_cnt == C_ACT_LAST) begin
            w_state_next = S_WRITE;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 8'd1;
          end
        end
        S_WRITE: begin
          xout_ena   = 1'b1;
          xout_wea   = 8'hFF;
          xout_addra = r_cnt[ADDR_W-1:0];
          xout_sel   = r_cnt[1:0];
          if (r_cnt == C_WR_LAST) begin
            w_state_next = S_DONE;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 8'd1;
          end
        end
        S_DONE: begin
          done         = 1'b1;
          w_state_next = S_IDLE;
        end
        default: w_state_next = S_IDLE;
      endcase
    end
    if (clr) begin
      w_state_next = S_IDLE;
      w_cnt_next   = '0;
    end
  end

  nn_cls_valid_dly #(
    .DEPTH(BRAM_LAT)
  ) u_valid_dly (
    .clk  (clk),
    .rst  (rst),
    .i_en (en),
    .i_clr(clr),
    .i_d  ({r_state == S_READ, r_state == S_BIAS}),
    .o_q  (w_dly_q)
  );

  assign ready      = (r_state == S_IDLE);
  assign mac_valid  = en & w_dly_q[1];
  assign bias_valid = en & w_dly_q[0];

endmodule

// File: tb/tb_nn_cls_scheduler.sv
// Bench for nn_cls_scheduler: a default instance and a BRAM_LAT=2/ACT_LAT=3 instance
// share stimulus; expected outputs come from the documented cycle schedule.
module tb_nn_cls_scheduler;

  localparam int NF = 9;
  localparam int NL = 3;

  typedef struct packed {
    logic       ready;
    logic       done;
    logic       xij_enb;
    logic [3:0] xij_addrb;
    logic       wb_enb;
    logic [3:0] wb_addrb;
    logic       acc_clr;
    logic       mac_valid;
    logic       bias_valid;
    logic       act_en;
    logic       xout_ena;
    logic [7:0] xout_wea;
    logic [3:0] xout_addra;
    logic [1:0] xout_sel;
  } outs_t;

  typedef struct {
    int cyc;
    outs_t e1;
    outs_t e2;
  } sb_t;

  typedef struct {
    int st_lo, st_hi, st2, stall_lo, stall_hi, clr_c, n_cyc, done1, done2;
  } scen_t;

  logic clk = 1'b0, rst = 1'b1, en = 1'b0, clr = 1'b0, start = 1'b0;
  outs_t w_o1, w_o2;
  sb_t   sb[$];
  scen_t tbl[4];
  int    n_checks = 0, n_fail = 0;
  int    s1, s2, d1, d2;

  always #5 clk = ~clk;

  logic       r1, dn1, xe1, we1, ac1, mv1, bv1, ae1, oe1;
  logic [3:0] xa1, wa1, oa1;
  logic [7:0] ow1;
  logic [1:0] os1;
  logic       r2, dn2, xe2, we2, ac2, mv2, bv2, ae2, oe2;
  logic [3:0] xa2, wa2, oa2;
  logic [7:0] ow2;
  logic [1:0] os2;

  nn_cls_scheduler u_dut1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .start(start),
    .ready(r1), .done(dn1), .xij_enb(xe1), .xij_addrb(xa1), .wb_enb(we1), .wb_addrb(wa1),
    .acc_clr(ac1), .mac_valid(mv1), .bias_valid(bv1), .act_en(ae1), .xout_ena(oe1),
    .xout_wea(ow1), .xout_addra(oa1), .xout_sel(os1)
  );

  nn_cls_scheduler #(.BRAM_LAT(2), .ACT_LAT(3)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .start(start),
    .ready(r2), .done(dn2), .xij_enb(xe2), .xij_addrb(xa2), .wb_enb(we2), .wb_addrb(wa2),
    .acc_clr(ac2), .mac_valid(mv2), .bias_valid(bv2), .act_en(ae2), .xout_ena(oe2),
    .xout_wea(ow2), .xout_addra(oa2), .xout_sel(os2)
  );

  assign w_o1 = {r1, dn1, xe1, xa1, we1, wa1, ac1, mv1, bv1, ae1, oe1, ow1, oa1, os1};
  assign w_o2 = {r2, dn2, xe2, xa2, we2, wa2, ac2, mv2, bv2, ae2, oe2, ow2, oa2, os2};

  // Expected outputs at schedule step s (0 = idle, 1 = first READ cycle).
  function automatic outs_t exp_at(int s, int lat, int act, logic en_i);
    outs_t e;
    int wr0, dn;
    e = '0;
    wr0 = NF + 2 + lat + act;
    dn  = wr0 + NL + 1;
    e.ready = (s == 0);
    if (en_i) begin
      if (s >= 1 && s <= NF) begin
        e.xij_enb   = 1'b1;
        e.wb_enb    = 1'b1;
        e.xij_addrb = 4'(s - 1);
        e.wb_addrb  = 4'(s - 1);
        e.acc_clr   = (s == 1);
      end
      if (s == NF + 1) begin
        e.wb_enb   = 1'b1;
        e.wb_addrb = 4'(NF);
      end
      e.mac_valid  = (s >= 1 + lat && s <= NF + lat);
      e.bias_valid = (s == NF + 1 + lat);
      e.act_en     = (s == NF + 2 + lat);
      if (s >= wr0 && s <= wr0 + NL) begin
        e.xout_ena   = 1'b1;
        e.xout_wea   = 8'hFF;
        e.xout_addra = 4'(s - wr0);
        e.xout_sel   = 2'(s - wr0);
      end
      e.done = (s == dn);
    end
    return e;
  endfunction

  function automatic int next_step(int s, int dn, logic en_i, logic st_i, logic clr_i);
    if (clr_i) return 0;
    if (!en_i) return s;
    if (s == 0) return st_i ? 1 : 0;
    if (s == dn) return 0;
    return s + 1;
  endfunction

  task automatic check(input string nm, input int cyc, input outs_t act, input outs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; en = 1'b0; start = 1'b0; clr = 1'b0;
    #1;
    check("reset_dflt", -1, w_o1, exp_at(0, 1, 2, 1'b1));
    check("reset_lat2", -1, w_o2, exp_at(0, 2, 3, 1'b1));
    s1 = 0; s2 = 0; d1 = -1; d2 = -1;
  endtask

  task automatic run_cycle(input int c, input logic en_i, input logic st_i, input logic clr_i);
    sb_t e;
    @(posedge clk);
    #1;
    rst = 1'b0; en = en_i; start = st_i; clr = clr_i;
    sb.push_back('{c, exp_at(s1, 1, 2, en_i), exp_at(s2, 2, 3, en_i)});
    @(negedge clk);
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_empty cyc=%0d", c);
    end else begin
      e = sb.pop_front();
      check("sched_dflt", e.cyc, w_o1, e.e1);
      check("sched_lat2", e.cyc, w_o2, e.e2);
    end
    if (dn1 && d1 < 0) d1 = c;
    if (dn2 && d2 < 0) d2 = c;
    s1 = next_step(s1, 18, en_i, st_i, clr_i);
    s2 = next_step(s2, 20, en_i, st_i, clr_i);
  endtask

  initial begin
    // st_lo, st_hi, st2, stall_lo, stall_hi, clr_c, n_cyc, done1, done2
    tbl[0] = '{0, 0,  -1, -1, -1, -1, 24, 18, 20};  // single inference
    tbl[1] = '{0, 0,  -1,  5,  7, -1, 26, 21, 23};  // en low in cycles 5..7
    tbl[2] = '{0, 0,   8, -1, -1,  6, 32, 26, 28};  // clr mid-READ, restart at 8
    tbl[3] = '{0, 29, -1, -1, -1, -1, 32, 18, 20};  // start held high

    for (int t = 0; t < 4; t++) begin
      do_reset();
      for (int c = 0; c < tbl[t].n_cyc; c++) begin
        run_cycle(c,
                  !(c >= tbl[t].stall_lo && c <= tbl[t].stall_hi),
                  (c >= tbl[t].st_lo && c <= tbl[t].st_hi) || (c == tbl[t].st2),
                  (c == tbl[t].clr_c));
      end
      check_int("done_cycle_dflt", d1, tbl[t].done1);
      check_int("done_cycle_lat2", d2, tbl[t].done2);
      $display("scenario %0d: done at cycle %0d / %0d", t, d1, d2);
    end

    // Asynchronous reset in cycle 15, while the default instance writes lane 1.
    do_reset();
    for (int c = 0; c < 15; c++) run_cycle(c, 1'b1, c == 0, 1'b0);
    @(posedge clk);
    #1;
    en = 1'b1; start = 1'b0; clr = 1'b0;
    #1;
    check("pre_rst_dflt", 15, w_o1, exp_at(s1, 1, 2, 1'b1));
    check("pre_rst_lat2", 15, w_o2, exp_at(s2, 2, 3, 1'b1));
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_dflt", 15, w_o1, exp_at(0, 1, 2, 1'b1));
    check("async_rst_lat2", 15, w_o2, exp_at(0, 2, 3, 1'b1));
    s1 = 0; s2 = 0;
    for (int c = 16; c < 26; c++) run_cycle(c, 1'b1, 1'b0, 1'b0);
    check_int("rst_no_done_dflt", d1, -1);
    check_int("rst_no_done_lat2", d2, -1);
    $display("scenario rst-mid-write: done at cycle %0d / %0d", d1, d2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nn_cls_scheduler.md
NN_CLS_SCHEDULER -- requirements
Module: nn_cls_scheduler

Interface
REQ-001 SHALL have parameters: N_FEAT default 9, input rows per inference; N_LANE default 3, parallel MAC lanes; ADDR_W default 4, BRAM address width; BRAM_LAT default 1, BRAM read latency in cycles; ACT_LAT default 2, activation latency in cycles.
REQ-002 SHALL use one clock; reset is asynchronous and active-high. Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- en  in  1  global advance enable; 0 freezes all state.
- clr  in  1  synchronous abort to IDLE.
- start  in  1  inference request; accepted only while ready=1.
- ready  out  1  high in IDLE.
- done  out  1  one-cycle completion pulse.
- xij_enb  out  1  feature BRAM port-b enable.
- xij_addrb  out  ADDR_W  feature BRAM read address.
- wb_enb  out  1  weight/bias BRAM port-b enable.
- wb_addrb  out  ADDR_W  weight/bias BRAM read address.
- acc_clr  out  1  clears lane accumulators.
- mac_valid  out  1  BRAM data valid for a multiply-accumulate step.
- bias_valid  out  1  bias word valid on wb_doutb.
- act_en  out  1  starts activation on the accumulated sums.
- xout_ena  out  1  result BRAM port-a enable.
- xout_wea  out  8  result BRAM write enable; 8'hFF when writing, else 0.
- xout_addra  out  ADDR_W  result BRAM write address.
- xout_sel  out  2  result mux select: 0..N_LANE-1 = lane activation, N_LANE = unhealthy flag.

Function
REQ-003 SHALL implement the FSM states IDLE, READ, BIAS, DRAIN, ACT, WRITE and DONE.
REQ-004 IDLE: start=1 with en=1 SHALL move to READ. Call this cycle 0.
REQ-005 READ SHALL last N_FEAT cycles (cycles 1..N_FEAT). In cycle k it drives xij_addrb=wb_addrb=k-1 with both enables high. acc_clr SHALL pulse in cycle 1 only.
REQ-006 BIAS SHALL last 1 cycle. It drives wb_addrb=N_FEAT with wb_enb=1 and xij_enb=0.
REQ-007 mac_valid SHALL assert exactly BRAM_LAT cycles after each READ address issue (cycles 1+BRAM_LAT..N_FEAT+BRAM_LAT). bias_valid SHALL assert BRAM_LAT cycles after BIAS. Both SHALL come from one delay line.
REQ-008 DRAIN SHALL last BRAM_LAT cycles. ACT SHALL last ACT_LAT cycles, with act_en high in the first ACT cycle only.
REQ-009 WRITE SHALL last N_LANE+1 cycles. In write cycle j it drives xout_ena=1, xout_wea=8'hFF, xout_addra=j and xout_sel=j. Address N_LANE holds the unhealthy flag.
REQ-010 DONE SHALL last 1 cycle with done=1, then return to IDLE. With defaults, done is high in cycle 18 and ready is high in cycle 19.
REQ-011 All BRAM enables, write enables and strobes SHALL be 0 outside the states and cycles defined above. Addresses SHALL hold 0 when their port is idle.
REQ-012 en=0 SHALL hold the state, all counters and the delay line. Strobe outputs SHALL be 0 while en=0, and the sequence SHALL resume at the same step when en returns to 1.
REQ-013 start outside IDLE SHALL be ignored. No start is queued.
REQ-014 clr=1 SHALL force IDLE, zero the counters and the delay line, and deassert all strobes on the next edge. clr SHALL override start in the same cycle and SHALL act regardless of en.
REQ-015 The address counters SHALL never exceed N_FEAT. The write counter SHALL never exceed N_LANE.

Reset
REQ-016 Asserting rst SHALL immediately force IDLE with ready=1 and set every other output and counter to 0, including mid-sequence.
REQ-017 The first start SHALL be accepted on the first clk edge after rst deasserts.

Structure
REQ-018 Package nn_cls_pkg SHALL hold the state enum, the N_FEAT/N_LANE defaults, DATA_W=16 and the Q6.10 format constants.
REQ-019 The valid-alignment delay line SHALL be the sub-module nn_cls_valid_dly, a shift register of depth BRAM_LAT that is 2 bits wide (mac, bias). All other logic SHALL be inline.

Verification
REQ-020 Reset, then start pulsed at cycle 0 -> addresses 0..8 in cycles 1..9, wb_addrb=9 in cycle 10, mac_valid in cycles 2..10, bias_valid in cycle 11, act_en in cycle 12, writes to addresses 0..3 in cycles 14..17, done in cycle 18.
REQ-021 start held high for 30 cycles -> exactly one inference, and a second starts in cycle 19.
REQ-022 en=0 during cycles 5..7 -> the whole schedule shifts by 3 cycles, with no strobes while en=0 and done in cycle 21.
REQ-023 clr in cycle 6 -> ready=1 in cycle 7 with no writes; a following start runs the full schedule.
REQ-024 rst asserted in cycle 15, during WRITE -> outputs clear asynchronously, and the write to address 2 is never issued.
REQ-025 BRAM_LAT=2 and ACT_LAT=3 -> mac_valid in cycles 3..11 and done in cycle 20.
